// File: rtl/fetch_issue_ctrl.sv
// Fetch sequencer for the dual-bank halfword-interleaved program ROM.
// Holds the halfword fetch PC, steers the ROM bank muxes and keeps a
// two-entry registered issue window for the decoder, with redirect,
// 32-bit prefix pairing and BKPT halt handling.
module fetch_issue_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned RESET_PC  = 0,
    parameter bit          BKPT_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pc_1,
    output logic              sel_mem_1,
    output logic [1:0]        sel_mem_0,
    input  logic [15:0]       rom_ir0,
    input  logic [15:0]       rom_ir1,
    input  logic              redirect_valid,
    input  logic [ADDR_W:0]   redirect_pc,
    input  logic [1:0]        issue_cnt,
    output logic              ir0_valid,
    output logic [15:0]       ir0,
    output logic [ADDR_W:0]   ir0_pc,
    output logic              ir0_wide,
    output logic              ir1_valid,
    output logic [15:0]       ir1,
    output logic [ADDR_W:0]   ir1_pc,
    output logic              halted
);

    localparam int unsigned PW = ADDR_W + 1;
    localparam logic [ADDR_W:0] PC_RST = PW'(RESET_PC);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [ADDR_W:0] fpc, fpc_n;
    logic            s0_v, s1_v, s0_v_n, s1_v_n;
    logic [15:0]     s0_n, s1_n;
    logic [ADDR_W:0] s0_pc_n, s1_pc_n;
    logic            wide_n, ir0_valid_n, ir1_valid_n;
    logic [1:0]      take;
    logic            bkpt_hit;

    // ROM row address and bank phase come straight from the fetch PC
    assign rom_addr = fpc[ADDR_W:1];
    assign pc_1     = fpc[0];

    // Clamp the decoder's request to what the window can actually issue
    always_comb begin
        take = 2'd0;
        if (ir0_valid) begin
            if (ir0_wide) begin
                take = (issue_cnt >= 2'd2) ? 2'd2 : 2'd0;
            end else if (ir1_valid) begin
                take = (issue_cnt >= 2'd2) ? 2'd2 : issue_cnt;
            end else begin
                take = (issue_cnt != 2'd0) ? 2'd1 : 2'd0;
            end
        end
        bkpt_hit = BKPT_HALT && (take != 2'd0) && (ir0[15:8] == 8'hBE);
    end

    // Next-state, fetch PC and issue window update
    always_comb begin
        state_n = state;
        fpc_n   = fpc;
        s0_v_n  = s0_v;
        s1_v_n  = s1_v;
        s0_n    = ir0;
        s1_n    = ir1;
        s0_pc_n = ir0_pc;
        s1_pc_n = ir1_pc;

        unique case (state)
            ST_FILL: begin
                s0_v_n  = 1'b1;
                s1_v_n  = 1'b1;
                s0_n    = rom_ir0;
                s1_n    = rom_ir1;
                s0_pc_n = fpc;
                s1_pc_n = fpc + PW'(1);
                fpc_n   = fpc + PW'(2);
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (bkpt_hit) begin
                    s0_v_n  = 1'b0;
                    s1_v_n  = 1'b0;
                    state_n = ST_HALT;
                end else if (take == 2'd1) begin
                    s0_v_n  = s1_v;
                    s0_n    = ir1;
                    s0_pc_n = ir1_pc;
                    s1_v_n  = 1'b1;
                    s1_n    = rom_ir0;
                    s1_pc_n = fpc;
                    fpc_n   = fpc + PW'(1);
                end else if (take == 2'd2) begin
                    s0_v_n  = 1'b1;
                    s1_v_n  = 1'b1;
                    s0_n    = rom_ir0;
                    s1_n    = rom_ir1;
                    s0_pc_n = fpc;
                    s1_pc_n = fpc + PW'(1);
                    fpc_n   = fpc + PW'(2);
                end
            end
            ST_HALT: begin
                s0_v_n = 1'b0;
                s1_v_n = 1'b0;
            end
            default: begin
                state_n = ST_FILL;
            end
        endcase

        // Redirect overrides everything, including a BKPT consume
        if (redirect_valid) begin
            s0_v_n  = 1'b0;
            s1_v_n  = 1'b0;
            fpc_n   = redirect_pc;
            state_n = ST_FILL;
        end

        wide_n      = s0_v_n && (s0_n[15:11] inside {5'b11101, 5'b11110, 5'b11111});
        ir0_valid_n = s0_v_n && (!wide_n || s1_v_n);
        ir1_valid_n = s1_v_n && !wide_n;
    end

    // State, fetch PC, window contents and issue flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            fpc       <= PC_RST;
            s0_v      <= 1'b0;
            s1_v      <= 1'b0;
            ir0       <= '0;
            ir1       <= '0;
            ir0_pc    <= '0;
            ir1_pc    <= '0;
            ir0_valid <= 1'b0;
            ir1_valid <= 1'b0;
            ir0_wide  <= 1'b0;
            halted    <= 1'b0;
            sel_mem_0 <= PC_RST[0] ? 2'd2 : 2'd0;
            sel_mem_1 <= ~PC_RST[0];
        end else begin
            state     <= state_n;
            fpc       <= fpc_n;
            s0_v      <= s0_v_n;
            s1_v      <= s1_v_n;
            ir0       <= s0_n;
            ir1       <= s1_n;
            ir0_pc    <= s0_pc_n;
            ir1_pc    <= s1_pc_n;
            ir0_valid <= ir0_valid_n;
            ir1_valid <= ir1_valid_n;
            ir0_wide  <= wide_n;
            halted    <= (state_n == ST_HALT);
            sel_mem_0 <= fpc_n[0] ? 2'd2 : 2'd0;
            sel_mem_1 <= ~fpc_n[0];
        end
    end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: expected window state is queued
// with each step and compared one cycle later against the DUT.
module tb_fetch_issue_ctrl;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic              pc_1;
    logic              sel_mem_1;
    logic [1:0]        sel_mem_0;
    logic [15:0]       rom_ir0, rom_ir1;
    logic              redirect_valid;
    logic [ADDR_W:0]   redirect_pc;
    logic [1:0]        issue_cnt;
    logic              ir0_valid, ir0_wide, ir1_valid, halted;
    logic [15:0]       ir0, ir1;
    logic [ADDR_W:0]   ir0_pc, ir1_pc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        bit          dat;
        logic        v0, v1, w, h;
        logic [15:0] i0, i1;
        logic [14:0] p0, p1;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] mem [16];
    logic [14:0] fpc_tb;
    assign fpc_tb  = {rom_addr, pc_1};
    assign rom_ir0 = mem[fpc_tb[3:0]];
    assign rom_ir1 = mem[4'(fpc_tb[3:0] + 4'd1)];

    always #5 clk = ~clk;

    fetch_issue_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(0), .BKPT_HALT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .pc_1(pc_1),
        .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
        .rom_ir0(rom_ir0), .rom_ir1(rom_ir1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .issue_cnt(issue_cnt),
        .ir0_valid(ir0_valid), .ir0(ir0), .ir0_pc(ir0_pc), .ir0_wide(ir0_wide),
        .ir1_valid(ir1_valid), .ir1(ir1), .ir1_pc(ir1_pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input bit dat, input logic v0, input logic v1,
                        input logic w, input logic h, input logic [15:0] i0,
                        input logic [14:0] p0, input logic [15:0] i1, input logic [14:0] p1);
        exp_t e;
        e.tag = tag; e.dat = dat; e.v0 = v0; e.v1 = v1; e.w = w; e.h = h;
        e.i0 = i0; e.p0 = p0; e.i1 = i1; e.p1 = p1;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, then compare against the oldest queued expectation
    task automatic step(input logic [1:0] cnt, input logic rv, input logic [14:0] rpc);
        exp_t e;
        issue_cnt      = cnt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        issue_cnt      = 2'd0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".v0"}, 32'(ir0_valid), 32'(e.v0));
            chk({e.tag, ".v1"}, 32'(ir1_valid), 32'(e.v1));
            chk({e.tag, ".wide"}, 32'(ir0_wide), 32'(e.w));
            chk({e.tag, ".halted"}, 32'(halted), 32'(e.h));
            if (e.dat) begin
                chk({e.tag, ".ir0"}, 32'(ir0), 32'(e.i0));
                chk({e.tag, ".pc0"}, 32'(ir0_pc), 32'(e.p0));
                chk({e.tag, ".ir1"}, 32'(ir1), 32'(e.i1));
                chk({e.tag, ".pc1"}, 32'(ir1_pc), 32'(e.p1));
            end
        end
    endtask

    task automatic check_rom_if(input string tag, input logic [13:0] ra, input logic p1,
                                input logic [1:0] s0, input logic s1);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(ra));
        chk({tag, ".pc_1"}, 32'(pc_1), 32'(p1));
        chk({tag, ".sel_mem_0"}, 32'(sel_mem_0), 32'(s0));
        chk({tag, ".sel_mem_1"}, 32'(sel_mem_1), 32'(s1));
    endtask

    task automatic do_reset(input string tag);
        rst_n          = 1'b0;
        issue_cnt      = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".v0"}, 32'(ir0_valid), 32'd0);
        chk({tag, ".v1"}, 32'(ir1_valid), 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
        chk({tag, ".ir0"}, 32'(ir0), 32'd0);
        check_rom_if(tag, 14'd0, 1'b0, 2'd0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        issue_cnt      = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // ROM image A
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[0] = 16'h2101; mem[1] = 16'h220C; mem[2] = 16'h23FF; mem[3] = 16'hB24C;
        mem[4] = 16'hB25C; mem[5] = 16'hB2DC; mem[6] = 16'hB21D; mem[7] = 16'h029B;
        mem[8] = 16'hB21D; mem[9] = 16'hB29D;

        do_reset("rst_a");
        push("fill", 1, 1, 1, 0, 0, 16'h2101, 15'd0, 16'h220C, 15'd1);
        step(2'd0, 1'b0, '0);
        push("hold", 1, 1, 1, 0, 0, 16'h2101, 15'd0, 16'h220C, 15'd1);
        step(2'd0, 1'b0, '0);
        push("take1", 1, 1, 1, 0, 0, 16'h220C, 15'd1, 16'h23FF, 15'd2);
        step(2'd1, 1'b0, '0);
        check_rom_if("odd_fpc", 14'd1, 1'b1, 2'd2, 1'b0);

        do_reset("rst_b");
        push("fill_b", 1, 1, 1, 0, 0, 16'h2101, 15'd0, 16'h220C, 15'd1);
        step(2'd0, 1'b0, '0);
        push("take2", 1, 1, 1, 0, 0, 16'h23FF, 15'd2, 16'hB24C, 15'd3);
        step(2'd2, 1'b0, '0);
        push("clamp3", 1, 1, 1, 0, 0, 16'hB25C, 15'd4, 16'hB2DC, 15'd5);
        step(2'd3, 1'b0, '0);
        push("redir_bubble", 0, 0, 0, 0, 0, 16'h0, 15'd0, 16'h0, 15'd0);
        step(2'd2, 1'b1, 15'd5);
        push("redir_fill", 1, 1, 1, 0, 0, 16'hB2DC, 15'd5, 16'hB21D, 15'd6);
        step(2'd0, 1'b0, '0);
        push("after_redir_take1", 1, 1, 1, 0, 0, 16'hB21D, 15'd6, 16'h029B, 15'd7);
        step(2'd1, 1'b0, '0);
        check_rom_if("even_fpc", 14'd4, 1'b0, 2'd0, 1'b1);

        // ROM image B: 32-bit pair followed by BKPT
        foreach (mem[i]) mem[i] = 16'h4000;
        mem[0] = 16'hF000; mem[1] = 16'hF800; mem[2] = 16'hBE00; mem[3] = 16'h1234;

        do_reset("rst_c");
        push("wide_fill", 1, 1, 0, 1, 0, 16'hF000, 15'd0, 16'hF800, 15'd1);
        step(2'd0, 1'b0, '0);
        push("wide_take1", 1, 1, 0, 1, 0, 16'hF000, 15'd0, 16'hF800, 15'd1);
        step(2'd1, 1'b0, '0);
        push("wide_take2", 1, 1, 1, 0, 0, 16'hBE00, 15'd2, 16'h1234, 15'd3);
        step(2'd2, 1'b0, '0);
        push("redir_beats_bkpt", 0, 0, 0, 0, 0, 16'h0, 15'd0, 16'h0, 15'd0);
        step(2'd1, 1'b1, 15'd2);
        push("refill_bkpt", 1, 1, 1, 0, 0, 16'hBE00, 15'd2, 16'h1234, 15'd3);
        step(2'd0, 1'b0, '0);
        push("bkpt_halt", 0, 0, 0, 0, 1, 16'h0, 15'd0, 16'h0, 15'd0);
        step(2'd1, 1'b0, '0);
        push("halt_hold", 0, 0, 0, 0, 1, 16'h0, 15'd0, 16'h0, 15'd0);
        step(2'd2, 1'b0, '0);
        push("halt_redir", 0, 0, 0, 0, 0, 16'h0, 15'd0, 16'h0, 15'd0);
        step(2'd0, 1'b1, 15'd0);
        push("halt_refill", 1, 1, 0, 1, 0, 16'hF000, 15'd0, 16'hF800, 15'd1);
        step(2'd0, 1'b0, '0);
        push("run_again", 1, 1, 1, 0, 0, 16'hBE00, 15'd2, 16'h1234, 15'd3);
        step(2'd2, 1'b0, '0);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.v0", 32'(ir0_valid), 32'd0);
        chk("async_rst.v1", 32'(ir1_valid), 32'd0);
        chk("async_rst.halted", 32'(halted), 32'd0);
        chk("async_rst.ir0", 32'(ir0), 32'd0);
        chk("async_rst.pc0", 32'(ir0_pc), 32'd0);
        chk("async_rst.rom_addr", 32'(rom_addr), 32'd0);
        chk("async_rst.pc_1", 32'(pc_1), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
